// File: rtl/iob_uart_tx_arb.sv
// iob_uart_tx_arb -- round-robin arbiter that feeds N_REQ byte streams into a
// single UART transmitter core.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/data/last   per-requester byte offer (byte i at req_data[8i+7:8i])
//   req_ready             accept strobe, high for the owner in SEND only
//   grant                 one-hot current owner, zero when idle
//   tx_ready              UART core can take a byte
//   tx_data, tx_write_en  byte and one-cycle load strobe to the UART core
//   busy                  FSM not in IDLE
//   tx_count              bytes written to the UART core (wraps)
//
// Optional feature: define IOB_UART_ARB_LOCK_EN to keep the grant across a
// whole message (until a byte with req_last=1). Without it every byte
// re-arbitrates and req_last is ignored.
//
// Byte timing: IDLE(arb) -> SEND(handshake) -> WAIT(write strobe, 2 guard
// cycles, then wait for tx_ready) -> IDLE / HOLD.
module iob_uart_tx_arb #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_write_en,
  output logic               busy,
  output logic [CNT_W-1:0]   tx_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] GUARD_CYC = 2'd2;

`ifdef IOB_UART_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;
`endif

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      last_owner_q, last_owner_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_we_q, tx_we_d;
  logic [1:0]         guard_q, guard_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
`ifdef IOB_UART_ARB_LOCK_EN
  logic               last_flag_q, last_flag_d;
`else
  logic               unused_req_last;
  assign unused_req_last = ^req_last;
`endif

  // Round-robin search starting just after the previous owner.
  logic [IW-1:0] rr_idx;
  logic          rr_hit;
  int            rr_i;
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    rr_i   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_i = int'(last_owner_q) + k;
      if (rr_i >= N_REQ) rr_i = rr_i - N_REQ;
      if (!rr_hit && req_valid[IW'(rr_i)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(rr_i);
      end
    end
  end

  // The owner index is always last_owner_q while a grant is held.
  logic hs;
  assign req_ready   = (state_q == SEND) ? grant_q : '0;
  assign hs          = |(req_valid & req_ready);
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_write_en = tx_we_q;
  assign busy        = (state_q != IDLE);
  assign tx_count    = tx_count_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    tx_data_d    = tx_data_q;
    tx_we_d      = 1'b0;
    guard_d      = guard_q;
    tx_count_d   = tx_we_q ? tx_count_q + 1'b1 : tx_count_q;
`ifdef IOB_UART_ARB_LOCK_EN
    last_flag_d  = last_flag_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_ready && rr_hit) begin
          grant_d      = N_REQ'(1) << rr_idx;
          last_owner_d = rr_idx;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          tx_data_d   = req_data[{last_owner_q, 3'b000} +: 8];
          tx_we_d     = 1'b1;
`ifdef IOB_UART_ARB_LOCK_EN
          last_flag_d = req_last[last_owner_q];
`endif
        end
        guard_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // tx_ready is only trusted once the core has had time to drop it
        // in response to the write strobe.
        if (guard_q != GUARD_CYC) begin
          guard_d = guard_q + 2'd1;
        end else if (tx_ready) begin
`ifdef IOB_UART_ARB_LOCK_EN
          if (!last_flag_q) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`else
          state_d = IDLE;
          grant_d = '0;
`endif
        end
      end
`ifdef IOB_UART_ARB_LOCK_EN
      HOLD: begin
        // Message locked: only the current owner can continue.
        if (req_valid[last_owner_q] && tx_ready) state_d = SEND;
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      tx_data_q    <= '0;
      tx_we_q      <= 1'b0;
      guard_q      <= '0;
      tx_count_q   <= '0;
`ifdef IOB_UART_ARB_LOCK_EN
      last_flag_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      tx_data_q    <= tx_data_d;
      tx_we_q      <= tx_we_d;
      guard_q      <= guard_d;
      tx_count_q   <= tx_count_d;
`ifdef IOB_UART_ARB_LOCK_EN
      last_flag_q  <= last_flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Directed bench for iob_uart_tx_arb: expected UART bytes are queued when a
// requester offers them and popped when tx_write_en fires. A second instance
// with CNT_W=4 shares the stimulus to exercise counter wrap.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s obs=%0h exp=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_iob_uart_tx_arb;
  logic        clk, rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_ready, tx_write_en, busy;
  logic [7:0]  tx_data;
  logic [15:0] tx_count;
  logic [3:0]  req_ready4, grant4, tx_count4;
  logic [7:0]  tx_data4;
  logic        tx_write_en4, busy4;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  iob_uart_tx_arb #(.N_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_write_en(tx_write_en),
    .busy(busy), .tx_count(tx_count));

  iob_uart_tx_arb #(.N_REQ(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready4), .grant(grant4),
    .tx_ready(tx_ready), .tx_data(tx_data4), .tx_write_en(tx_write_en4),
    .busy(busy4), .tx_count(tx_count4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest queued byte.
  always @(negedge clk) begin
    if (tx_write_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL tx_extra obs=%0h exp=none", tx_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        `CHK("tx_data", tx_data, mon_e)
      end
      wr_cnt++;
    end
  end

  task automatic wait_wr(input logic [3:0] g_exp, input bit chk_g);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (chk_g) `CHK("grant_hold", grant, g_exp)
      if (tx_write_en) seen = 1'b1;
    end
    `CHK("wr_timeout", seen, 1'b1)
  endtask

  task automatic idle_wait();
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    `CHK("idle", busy, 1'b0)
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '1; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    `CHK("rst_grant", grant, 4'b0000)
    `CHK("rst_ready", req_ready, 4'b0000)
    `CHK("rst_we", tx_write_en, 1'b0)
    `CHK("rst_data", tx_data, 8'h00)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_count", tx_count, 16'd0)

    // Single byte latency: ready at cycle 1, write at cycle 2.
    rst = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h41; tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    `CHK("c1_ready", req_ready, 4'b0001)
    `CHK("c1_grant", grant, 4'b0001)
    `CHK("c1_we", tx_write_en, 1'b0)
    `CHK("c1_busy", busy, 1'b1)
    @(negedge clk);
    `CHK("c2_we", tx_write_en, 1'b1)
    `CHK("c2_data", tx_data, 8'h41)
    `CHK("c2_ready", req_ready, 4'b0000)
    req_valid = '0;
    idle_wait();
    `CHK("count1", tx_count, 16'd1)

    // All four requesters continuously valid: rotation 0,1,2,3,0.
    rst_pulse();
    req_data = 32'h13121110; req_valid = 4'hF;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h13); exp_q.push_back(8'h10);
    for (int n = 0; n < 5; n++) wait_wr(4'b0000, 1'b0);
    req_valid = '0;
    idle_wait();
    `CHK("rr_count", tx_count, 16'd5)
    `CHK("rr_qempty", exp_q.size(), 0)

    // UART not ready for 20 cycles: no further activity, busy held.
    req_valid = 4'b0001; req_data[7:0] = 8'h55;
    exp_q.push_back(8'h55);
    wait_wr(4'b0000, 1'b0);
    tx_ready = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'h66;
    exp_q.push_back(8'h66);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      `CHK("stall_ready", req_ready, 4'b0000)
      `CHK("stall_we", tx_write_en, 1'b0)
      `CHK("stall_busy", busy, 1'b1)
    end
    tx_ready = 1'b1;
    wait_wr(4'b0000, 1'b0);
    req_valid = '0;
    idle_wait();
    `CHK("stall_count", tx_count, 16'd7)

    // Reset during WAIT aborts; next grant goes to lowest valid index.
    req_valid = 4'b0100; req_data[23:16] = 8'h77;
    exp_q.push_back(8'h77);
    wait_wr(4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    `CHK("arst_grant", grant, 4'b0000)
    `CHK("arst_ready", req_ready, 4'b0000)
    `CHK("arst_we", tx_write_en, 1'b0)
    `CHK("arst_data", tx_data, 8'h00)
    `CHK("arst_busy", busy, 1'b0)
    `CHK("arst_count", tx_count, 16'd0)
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0110; req_data[15:8] = 8'h88;
    exp_q.push_back(8'h88);
    @(negedge clk);
    `CHK("arst_regrant", grant, 4'b0010)
    wait_wr(4'b0000, 1'b0);
    req_valid = '0;
    idle_wait();
    `CHK("arst_count1", tx_count, 16'd1)

`ifdef IOB_UART_ARB_LOCK_EN
    // Locked message of three bytes from requester 2, requester 1 waits.
    rst_pulse();
    req_valid = 4'b0100; req_last = 4'b0000; req_data[23:16] = 8'hA0;
    exp_q.push_back(8'hA0);
    wait_wr(4'b0000, 1'b0);
    req_valid = 4'b0110; req_data[15:8] = 8'hB1; req_last[1] = 1'b1;
    req_data[23:16] = 8'hA1;
    exp_q.push_back(8'hA1);
    wait_wr(4'b0100, 1'b1);
    req_data[23:16] = 8'hA2; req_last[2] = 1'b1;
    exp_q.push_back(8'hA2);
    wait_wr(4'b0100, 1'b1);
    req_valid = 4'b0010;
    exp_q.push_back(8'hB1);
    wait_wr(4'b0000, 1'b0);
    `CHK("lock_next", grant, 4'b0010)
    req_valid = '0; req_last = '1;
    idle_wait();
`endif

    // 17 bytes: 4-bit counter wraps to 1.
    rst_pulse();
    req_valid = 4'b0001; req_data[7:0] = 8'h5A;
    for (int n = 0; n < 17; n++) exp_q.push_back(8'h5A);
    for (int n = 0; n < 17; n++) wait_wr(4'b0000, 1'b0);
    req_valid = '0;
    idle_wait();
    `CHK("wrap16", tx_count, 16'd17)
    `CHK("wrap4", tx_count4, 4'd1)
    `CHK("final_qempty", exp_q.size(), 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_uart_tx_arb.md
IOB_UART_TX_ARB -- requirements
Module: iob_uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the sent-byte counter.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte-valid.
REQ-006 SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  marks the final byte of a message; sampled with the byte.
REQ-008 SHALL have port req_ready  output  N_REQ  byte-accept strobe.
REQ-009 SHALL have port grant  output  N_REQ  one-hot current owner, all zero when idle.
REQ-010 SHALL have port tx_ready  input  1  UART core transmitter ready.
REQ-011 SHALL have port tx_data  output  8  byte to UART core.
REQ-012 SHALL have port tx_write_en  output  1  one-cycle load strobe to UART core.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port tx_count  output  CNT_W  total bytes written to the UART core.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT, HOLD (HOLD reachable only per REQ-024).
REQ-016 IDLE: when tx_ready=1 and any req_valid=1, SHALL register the round-robin winner into grant and go to SEND next cycle; otherwise stay.
REQ-017 Round-robin: search SHALL start at index (last_owner+1) mod N_REQ, ascending with wrap; last_owner updates on every grant.
REQ-018 SEND lasts exactly one cycle; req_ready[owner] SHALL equal 1 combinationally in SEND and 0 in all other states/bits; handshake = req_valid & req_ready.
REQ-019 Requesters SHALL hold req_valid and req_data stable until handshake; the block does not re-check req_valid in SEND.
REQ-020 On the SEND handshake the block SHALL register tx_data<=req_data[owner], last_flag<=req_last[owner], and assert tx_write_en for exactly the next cycle (first WAIT cycle).
REQ-021 Latency: req_valid high in IDLE with tx_ready=1 at cycle 0 -> req_ready at cycle 1 -> tx_write_en at cycle 2.
REQ-022 WAIT: 2-cycle guard counter SHALL run before tx_ready is sampled; exit when guard expired and tx_ready=1.
REQ-023 tx_count SHALL increment by 1 on each tx_write_en, wrapping from 2^CNT_W-1 to 0.
REQ-024 WAIT exit goes to IDLE with grant cleared, except per Configuration.
REQ-025 tx_data SHALL hold its last value when tx_write_en=0.
REQ-026 Simultaneous new req_valid on multiple lines SHALL be resolved only by REQ-017; a requester dropping req_valid before grant loses no state.

Reset
REQ-027 On rst=1 SHALL asynchronously force state IDLE, grant=0, req_ready=0, tx_write_en=0, tx_data=0, busy=0, tx_count=0, guard=0, last_owner=N_REQ-1 (requester 0 has first priority).
REQ-028 Reset asserted mid-operation SHALL abort the transfer with no tx_write_en issued after reset release unless a new arbitration occurs.

Configuration
REQ-029 Macro IOB_UART_ARB_LOCK_EN SHALL select message locking.
REQ-030 With IOB_UART_ARB_LOCK_EN defined: WAIT exit with last_flag=0 SHALL go to HOLD keeping grant; HOLD goes to SEND when req_valid[owner]=1 and tx_ready=1; other requesters are ignored; last_flag=1 exits to IDLE.
REQ-031 Without IOB_UART_ARB_LOCK_EN: req_last is ignored, HOLD is not implemented, every byte re-arbitrates via IDLE.

Verification
REQ-032 Reset then req_valid=4'b0001, data 0x41, tx_ready=1 -> req_ready[0] at cycle 1, tx_write_en with tx_data=0x41 at cycle 2, tx_count=1.
REQ-033 req_valid=4'b1111 held, data 0x10..0x13, tx_ready=1, lock off -> UART bytes 0x10,0x11,0x12,0x13,0x10 in order.
REQ-034 tx_ready held 0 for 20 cycles after first write -> no further req_ready or tx_write_en until tx_ready=1; busy=1 throughout.
REQ-035 Lock on: requester 2 sends 3 bytes (last on third) while requester 1 valid -> bytes 2,2,2 then requester 1; grant=4'b0100 constant through HOLD.
REQ-036 rst pulsed during WAIT -> all outputs zero, last_owner reset, next grant goes to lowest valid index.
REQ-037 CNT_W=4, 17 bytes sent -> tx_count wraps to 1.
